// File: rtl/riscv_pkg.sv
// Shared types and decode constants for the load/store path.
// Holds FSM states, load funct3 / store mask encodings and small decode helpers.
package riscv_pkg;

  localparam int LSU_DATA_W = 32;
  localparam int LSU_BE_W   = LSU_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_SB   = 4'b0001;
  localparam logic [3:0] MASK_SH   = 4'b0011;
  localparam logic [3:0] MASK_SW   = 4'b1111;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic acc_size_e load_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_LH, F3_LHU: sz = SZ_HALF;
      F3_LW:         sz = SZ_WORD;
      default:       sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  // Masks other than the listed ones are treated as byte-granular (no alignment rule).
  function automatic acc_size_e store_size(input logic [3:0] mask);
    acc_size_e sz;
    case (mask)
      MASK_SH: sz = SZ_HALF;
      MASK_SW: sz = SZ_WORD;
      default: sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && (off == 2'd3)) || ((sz == SZ_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword/word from a bus read word
// and sign- or zero-extends it according to the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [1:0]  hi_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_i[8*gi +: 8];
    end
  endgenerate

  // Offset 3 never reaches here for halfwords, so the wrap of hi_idx is harmless.
  assign hi_idx   = offset_i + 2'd1;
  assign byte_sel = lane[offset_i];
  assign half_sel = {lane[hi_idx], lane[offset_i]};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      F3_LW:   data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding req/ack data bus master with
// store lane shifting, alignment checks and extended load writeback data.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [3:0]        mem_write_mask_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [31:0]       load_data_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              fault_q, fault_d;

  logic        is_store, is_load, is_access;
  logic [1:0]  off;
  acc_size_e   size;
  logic        illegal, misaligned, accept, fault_now;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] aligned;

  // A store wins when both decode flags are raised.
  assign is_store  = valid_i & mem_write_i;
  assign is_load   = valid_i & mem_read_i & ~mem_write_i;
  assign is_access = is_store | is_load;
  assign off       = addr_i[1:0];

  assign size       = is_store ? store_size(mem_write_mask_i) : load_size(funct3_i);
  assign illegal    = (is_store & (mem_write_mask_i == MASK_NONE)) |
                      (is_load & ~load_f3_legal(funct3_i));
  assign misaligned = is_access & is_misaligned(size, off);

  assign accept    = (state_q == IDLE) & is_access & ~illegal & ~misaligned;
  assign fault_now = (state_q == IDLE) & is_access & (illegal | misaligned);

  assign st_be    = mem_write_mask_i << off;
  assign st_wdata = store_data_i << {off, 3'b000};

  load_align u_load_align (
    .word_i   (bus_rdata_i),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fault_now) begin
          fault_d = 1'b1;
        end else if (accept) begin
          state_d = REQ;
          addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          we_d    = is_store;
          be_d    = is_store ? st_be : MASK_SW;
          wdata_d = is_store ? st_wdata : '0;
          f3_d    = funct3_i;
          off_d   = off;
        end
      end
      REQ: begin
        if (bus_ack_i) begin
          state_d = DONE;
          if (!we_q) begin
            load_data_d = aligned;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_o     = accept | (state_q == REQ);
  assign done_o      = (state_q == DONE);
  assign fault_o     = fault_q;
  assign load_data_o = load_data_q;
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: stores, loads, faults,
// wait states and reset during an in-flight request.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mrd, mwr;
  logic [3:0]  mask;
  logic [2:0]  f3;
  logic [31:0] addr, sdata;
  logic        stall, done, fault;
  logic [31:0] ldata;
  logic        req, we;
  logic [31:0] baddr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_i          (valid),
    .mem_read_i       (mrd),
    .mem_write_i      (mwr),
    .mem_write_mask_i (mask),
    .funct3_i         (f3),
    .addr_i           (addr),
    .store_data_i     (sdata),
    .stall_o          (stall),
    .done_o           (done),
    .fault_o          (fault),
    .load_data_o      (ldata),
    .bus_req_o        (req),
    .bus_we_o         (we),
    .bus_addr_o       (baddr),
    .bus_be_o         (be),
    .bus_wdata_o      (wdata),
    .bus_rdata_i      (rdata),
    .bus_ack_i        (ack)
  );

  task automatic idle_inputs();
    valid = 0; mrd = 0; mwr = 0; mask = 4'b0; f3 = 3'b0;
    addr = 32'h0; sdata = 32'h0; ack = 0; rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({stall, done, fault, req, we} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b want=00000", {stall, done, fault, req, we});
    end
    n_cmp++;
    if ({ldata, baddr, be, wdata} !== 100'b0) begin
      n_err++; $display("FAIL reset_data ldata=%h baddr=%h be=%b wdata=%h want all zero", ldata, baddr, be, wdata);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("reset: outputs cleared");
  endtask

  task automatic test_sw();
    valid = 1; mwr = 1; mask = 4'b1111; addr = 32'h100; sdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({stall, req} !== 2'b10) begin
      n_err++; $display("FAIL sw_T stall/req got=%b want=10", {stall, req});
    end
    tick();
    n_cmp++;
    if ({req, we, stall, done, be, baddr, wdata} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL sw_T1 req=%b we=%b stall=%b done=%b be=%b baddr=%h wdata=%h want 1 1 1 0 1111 100 deadbeef",
                        req, we, stall, done, be, baddr, wdata);
    end
    ack = 1;
    tick();
    ack = 0;
    n_cmp++;
    if ({done, stall, req} !== 3'b100) begin
      n_err++; $display("FAIL sw_T2 done/stall/req got=%b want=100", {done, stall, req});
    end
    n_cmp++;
    if (ldata !== 32'h0) begin
      n_err++; $display("FAIL sw_ldata_unchanged got=%h want=00000000", ldata);
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL sw_done_one_cycle got=%b want=0", done);
    end
    $display("SW addr=00000100 be=%b wdata=%h", be, wdata);
  endtask

  task automatic test_sb();
    valid = 1; mwr = 1; mask = 4'b0001; addr = 32'h103; sdata = 32'h000000A5;
    tick();
    valid = 0;
    n_cmp++;
    if ({req, we, be, baddr, wdata} !== {1'b1, 1'b1, 4'b1000, 32'h100, 32'hA5000000}) begin
      n_err++; $display("FAIL sb_bus req=%b we=%b be=%b baddr=%h wdata=%h want 1 1 1000 100 a5000000",
                        req, we, be, baddr, wdata);
    end
    ack = 1;
    tick();
    ack = 0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL sb_done got=%b want=1", done);
    end
    idle_inputs();
    tick();
    $display("SB addr=00000103 be=%b wdata=%h", be, wdata);
  endtask

  // Loads issued back-to-back: the next one is presented the cycle after DONE.
  task automatic test_loads();
    logic [2:0]  tf3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  toff [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] texp [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                              32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 6; i++) begin
      valid = 1; mrd = 1; mwr = 0; f3 = tf3[i]; addr = 32'h200 | {30'd0, toff[i]};
      #1;
      n_cmp++;
      if ({stall, done} !== 2'b10) begin
        n_err++; $display("FAIL load%0d_T stall/done got=%b want=10", i, {stall, done});
      end
      tick();
      n_cmp++;
      if ({req, we, be, baddr} !== {1'b1, 1'b0, 4'b1111, 32'h200}) begin
        n_err++; $display("FAIL load%0d_bus req=%b we=%b be=%b baddr=%h want 1 0 1111 200", i, req, we, be, baddr);
      end
      ack = 1; rdata = 32'h80FF7F01;
      tick();
      ack = 0; rdata = 32'h0;
      n_cmp++;
      if ({done, ldata} !== {1'b1, texp[i]}) begin
        n_err++; $display("FAIL load%0d_data done=%b ldata=%h want 1 %h", i, done, ldata, texp[i]);
      end
      valid = 0; mrd = 0;
      tick();
      $display("LOAD f3=%b off=%0d ldata=%h", tf3[i], toff[i], ldata);
    end
  endtask

  task automatic test_faults();
    logic        trd   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0]  tmask [4] = '{4'b0000, 4'b0011, 4'b0000, 4'b0000};
    logic [2:0]  tf3   [4] = '{3'b010, 3'b000, 3'b000, 3'b011};
    logic [31:0] taddr [4] = '{32'h102, 32'h203, 32'h204, 32'h208};
    for (int i = 0; i < 4; i++) begin
      valid = 1; mrd = trd[i]; mwr = ~trd[i]; mask = tmask[i]; f3 = tf3[i]; addr = taddr[i];
      #1;
      n_cmp++;
      if ({stall, req, fault} !== 3'b000) begin
        n_err++; $display("FAIL fault%0d_T stall/req/fault got=%b want=000", i, {stall, req, fault});
      end
      tick();
      idle_inputs();
      #1;
      n_cmp++;
      if ({fault, req, stall} !== 3'b100) begin
        n_err++; $display("FAIL fault%0d_T1 fault/req/stall got=%b want=100", i, {fault, req, stall});
      end
      tick();
      n_cmp++;
      if ({fault, req, done, ldata} !== {3'b000, 32'h80FF7F01}) begin
        n_err++; $display("FAIL fault%0d_T2 fault=%b req=%b done=%b ldata=%h want 0 0 0 80ff7f01",
                          i, fault, req, done, ldata);
      end
      $display("FAULT case %0d addr=%h handled", i, taddr[i]);
    end
  endtask

  task automatic test_ignored();
    valid = 1; mrd = 0; mwr = 0; addr = 32'h300;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL nop_stall got=%b want=0", stall);
    end
    tick();
    valid = 0; ack = 1; rdata = 32'h11111111;
    tick();
    ack = 0;
    n_cmp++;
    if ({req, fault, done, ldata} !== {3'b000, 32'h80FF7F01}) begin
      n_err++; $display("FAIL nop_ack_ignored req=%b fault=%b done=%b ldata=%h want 0 0 0 80ff7f01",
                        req, fault, done, ldata);
    end
    idle_inputs();
    $display("NOP and stray ack ignored");
  endtask

  task automatic test_wait();
    int ok_cycles = 0;
    valid = 1; mrd = 1; f3 = 3'b001; addr = 32'h300;
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (req === 1'b1 && baddr === 32'h300 && stall === 1'b1 && done === 1'b0) ok_cycles++;
      if (k == 5) begin
        ack = 1; rdata = 32'h0000F00D;
      end
      tick();
    end
    ack = 0; rdata = 32'h0;
    n_cmp++;
    if (ok_cycles !== 5) begin
      n_err++; $display("FAIL wait_req_stable got=%0d want=5", ok_cycles);
    end
    n_cmp++;
    if ({done, stall, ldata} !== {2'b10, 32'hFFFFF00D}) begin
      n_err++; $display("FAIL wait_done done=%b stall=%b ldata=%h want 1 0 fffff00d", done, stall, ldata);
    end
    idle_inputs();
    tick();
    $display("WAIT load ldata=%h", ldata);
  endtask

  task automatic test_reset_mid_req();
    int done_seen = 0;
    valid = 1; mwr = 1; mask = 4'b1111; addr = 32'h400; sdata = 32'h12345678;
    tick();
    idle_inputs();
    n_cmp++;
    if (req !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_req got=%b want=1", req);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({req, we, stall, done, be, baddr, wdata, ldata} !== 104'b0) begin
      n_err++; $display("FAIL rst_async req=%b we=%b stall=%b done=%b be=%b baddr=%h wdata=%h ldata=%h want all 0",
                        req, we, stall, done, be, baddr, wdata, ldata);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++; $display("FAIL rst_no_done got=%0d want=0", done_seen);
    end
    valid = 1; mwr = 1; mask = 4'b1111; addr = 32'h104; sdata = 32'hCAFEF00D;
    tick();
    valid = 0;
    n_cmp++;
    if ({req, baddr, wdata} !== {1'b1, 32'h104, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL post_rst_sw req=%b baddr=%h wdata=%h want 1 104 cafef00d", req, baddr, wdata);
    end
    ack = 1;
    tick();
    ack = 0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL post_rst_done got=%b want=1", done);
    end
    idle_inputs();
    tick();
    $display("RESET mid-REQ recovered");
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_faults();
    test_ignored();
    test_wait();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
